fetch_stage: RTL
================

// Module: fetch_stage
// PURPOSE
//   Instruction-fetch stage and IF/ID pipeline register of the 5-stage WISC pipeline. Holds the PC and
//   issues reads to instruction memory, which may be multi-cycle (stall/done handshake). Captures
//   instr/PC+2 into IF/ID; if_id_instr[15:11] drives the decode control block's I_op.
//   Handles decode stalls, branch/jump redirects and halt.
// PARAMETERS
//   RESET_PC   16'h0000  PC loaded on reset
//   NOP_INSTR  16'h0800  bubble inserted into IF/ID (opcode 00001 = NOP; never 16'h0000 = HALT)
// PORTS
//   clk            in   1   clock, all state on posedge
//   rst            in   1   synchronous, active-high reset
//   imem_addr      out  16  fetch address (registered PC)
//   imem_rd        out  1   read request
//   imem_data      in   16  read data, valid when imem_done=1
//   imem_done      in   1   read complete this cycle (may be same cycle as imem_rd)
//   stall_id       in   1   hazard stall from decode: hold IF/ID and PC
//   redirect       in   1   branch taken / jump resolved in EX
//   redirect_pc    in   16  target for redirect
//   halt_id        in   1   valid HALT decoded in ID
//   if_id_instr    out  16  IF/ID instruction
//   if_id_pc2      out  16  IF/ID PC+2
//   if_id_valid    out  1   IF/ID holds a real instruction
//   fetch_halted   out  1   fetch frozen by HALT
//   perf_fetches   out  16  instructions delivered to IF/ID (feature-gated)
//   perf_stalls    out  16  cycles IF/ID held or bubbled for memory/stall (feature-gated)
// BEHAVIOUR
//   Reset: PC=RESET_PC, state=FETCH, if_id_instr=NOP_INSTR, if_id_pc2=0, if_id_valid=0,
//     fetch_halted=0, holding buffer empty, perf counters 0, imem_rd=0 in reset cycle.
//   States: FETCH, WAIT, HALTED. imem_addr=PC in all states.
//   FETCH: imem_rd=1 unless holding buffer full. done same cycle -> latency 1: instr in IF/ID at next
//     edge, PC+=2. done=0 -> WAIT, PC and imem_addr held stable.
//   WAIT: imem_rd held 1 until imem_done. Then capture as FETCH and return to FETCH.
//   stall_id=1: IF/ID and PC unchanged. A read completing during stall goes to a 1-entry holding
//     buffer (instr, PC+2); no new imem_rd while buffer full. When stall drops, buffer drains to
//     IF/ID first, then fetch resumes.
//   Fetch miss with no stall: if_id_instr=NOP_INSTR, if_id_valid=0 (bubble).
//   redirect=1 (beats stall_id): PC<=redirect_pc; IF/ID<=NOP, valid=0; holding buffer cleared.
//     In WAIT: keep imem_rd/addr until done, discard that data, then fetch redirect_pc
//     (pending-redirect flag). Same-cycle done+redirect: data discarded, PC<=redirect_pc.
//   halt_id=1 and no redirect: state->HALTED, fetch_halted=1, imem_rd=0, IF/ID<=NOP/valid=0.
//     In-flight WAIT read is discarded. HALTED left only by rst.
//   halt_id+redirect same cycle: redirect wins (older EX instruction flushes HALT); no halt.
//   PC arithmetic 16-bit, wraps 16'hFFFE->16'h0000 silently. redirect_pc[0] ignored (forced 0).
//   rst overrides everything mid-WAIT; a done arriving in the reset cycle is dropped.
// CONFIGURATION
//   FETCH_PERF_EN defined: perf_fetches increments per valid IF/ID load. perf_stalls increments
//     each cycle IF/ID is held or bubbled, not HALTED. Both saturate at 16'hFFFF.
//   FETCH_PERF_EN undefined: no counter logic; perf_fetches/perf_stalls tied to 16'h0000.
// TESTING
//   1-cycle memory, straight line from 0 -> IF/ID shows PC2 2,4,6 on consecutive cycles, valid=1.
//   done delayed 3 cycles at PC=4 -> imem_addr=4 held 4 cycles, 3 NOP bubbles, then PC2=6.
//   stall_id 2 cycles, read completes meanwhile -> IF/ID held, buffer used, no new imem_rd, then PC2 order intact.
//   redirect to 16'h0100 during WAIT -> late data discarded, next valid IF/ID PC2=16'h0102.
//   halt_id and redirect same cycle -> no halt. halt_id alone -> fetch_halted=1, imem_rd=0 until rst.
//   PC=16'hFFFE fetch -> PC2=16'h0000. FETCH_PERF_EN: 5 fetches + 3 stalls -> counters 5/3; undefined -> 0/0.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage and IF/ID register for the 5-stage WISC pipeline.
// Optional performance counters are built when FETCH_PERF_EN is defined.
module fetch_stage #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0800
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] imem_addr,
  output logic        imem_rd,
  input  logic [15:0] imem_data,
  input  logic        imem_done,
  input  logic        stall_id,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        halt_id,
  output logic [15:0] if_id_instr,
  output logic [15:0] if_id_pc2,
  output logic        if_id_valid,
  output logic        fetch_halted,
  output logic [15:0] perf_fetches,
  output logic [15:0] perf_stalls
);

  typedef enum logic [1:0] {S_FETCH, S_WAIT, S_HALTED} state_e;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] pc2_q, pc2_d;
  logic        valid_q, valid_d;
  logic        halted_q, halted_d;
  logic        buf_vld_q, buf_vld_d;
  logic [15:0] buf_instr_q, buf_instr_d;
  logic [15:0] buf_pc2_q, buf_pc2_d;
  logic        pend_q, pend_d;
  logic [15:0] pend_pc_q, pend_pc_d;

  logic        rd_ok;
  logic        done;
  logic [15:0] pc_inc;
  logic [15:0] redirect_tgt;
  logic        load_vld;
  logic        stall_cyc;
  logic        perf_unused;

  // Read is requested whenever the buffer has room, and kept up while a read is outstanding.
  assign rd_ok        = ((state_q == S_FETCH) && !buf_vld_q) || (state_q == S_WAIT);
  assign done         = rd_ok && imem_done;
  assign pc_inc       = pc_q + 16'd2;
  assign redirect_tgt = {redirect_pc[15:1], 1'b0};

  assign imem_addr    = pc_q;
  assign imem_rd      = rd_ok && !rst;
  assign if_id_instr  = instr_q;
  assign if_id_pc2    = pc2_q;
  assign if_id_valid  = valid_q;
  assign fetch_halted = halted_q;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    pc2_d       = pc2_q;
    valid_d     = valid_q;
    halted_d    = halted_q;
    buf_vld_d   = buf_vld_q;
    buf_instr_d = buf_instr_q;
    buf_pc2_d   = buf_pc2_q;
    pend_d      = pend_q;
    pend_pc_d   = pend_pc_q;
    load_vld    = 1'b0;
    stall_cyc   = 1'b0;

    if (state_q != S_HALTED) begin
      if (redirect) begin
        instr_d   = NOP_INSTR;
        valid_d   = 1'b0;
        buf_vld_d = 1'b0;
        // An outstanding read must finish at its own address before the target is fetched.
        if (rd_ok && !done) begin
          pend_d    = 1'b1;
          pend_pc_d = redirect_tgt;
          state_d   = S_WAIT;
        end else begin
          pend_d  = 1'b0;
          pc_d    = redirect_tgt;
          state_d = S_FETCH;
        end
      end else if (halt_id) begin
        state_d   = S_HALTED;
        halted_d  = 1'b1;
        instr_d   = NOP_INSTR;
        valid_d   = 1'b0;
        buf_vld_d = 1'b0;
        pend_d    = 1'b0;
      end else begin
        state_d = (rd_ok && !done) ? S_WAIT : S_FETCH;
        if (done) begin
          pend_d = 1'b0;
          pc_d   = pend_q ? pend_pc_q : pc_inc;
        end
        if (stall_id) begin
          stall_cyc = 1'b1;
          if (done && !pend_q) begin
            buf_vld_d   = 1'b1;
            buf_instr_d = imem_data;
            buf_pc2_d   = pc_inc;
          end
        end else if (buf_vld_q) begin
          instr_d   = buf_instr_q;
          pc2_d     = buf_pc2_q;
          valid_d   = 1'b1;
          buf_vld_d = 1'b0;
          load_vld  = 1'b1;
        end else if (done && !pend_q) begin
          instr_d  = imem_data;
          pc2_d    = pc_inc;
          valid_d  = 1'b1;
          load_vld = 1'b1;
        end else begin
          instr_d   = NOP_INSTR;
          valid_d   = 1'b0;
          stall_cyc = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      instr_q   <= NOP_INSTR;
      pc2_q     <= 16'h0000;
      valid_q   <= 1'b0;
      halted_q  <= 1'b0;
      buf_vld_q <= 1'b0;
      pend_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      pc2_q     <= pc2_d;
      valid_q   <= valid_d;
      halted_q  <= halted_d;
      buf_vld_q <= buf_vld_d;
      pend_q    <= pend_d;
    end
  end

  // Payload registers are qualified by buf_vld_q / pend_q and need no reset.
  always_ff @(posedge clk) begin
    buf_instr_q <= buf_instr_d;
    buf_pc2_q   <= buf_pc2_d;
    pend_pc_q   <= pend_pc_d;
  end

`ifdef FETCH_PERF_EN
  logic [15:0] perf_fetches_q, perf_stalls_q;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetches_q <= 16'h0000;
      perf_stalls_q  <= 16'h0000;
    end else begin
      if (load_vld)  perf_fetches_q <= sat_inc(perf_fetches_q);
      if (stall_cyc) perf_stalls_q  <= sat_inc(perf_stalls_q);
    end
  end

  assign perf_fetches = perf_fetches_q;
  assign perf_stalls  = perf_stalls_q;
  assign perf_unused  = redirect_pc[0];
`else
  assign perf_fetches = 16'h0000;
  assign perf_stalls  = 16'h0000;
  assign perf_unused  = ^{redirect_pc[0], load_vld, stall_cyc};
`endif

endmodule
